// File: rtl/plot_writer.sv
// plot_writer: turns Mandelbrot generator plot strobes into linear framebuffer
// writes for a 320x240, 3-bit-colour screen, decoupled by a small FIFO.
// Optional full-screen clear sweep is built only when FB_CLEAR_EN is defined.
// Ports:
//   clk, rst                      clock, async active-high reset
//   vga_x/vga_y/vga_colour        plot coordinate and colour
//   vga_plot                      plot strobe, one pixel per cycle
//   clear_start, clear_colour     clear request pulse and fill colour
//   fb_addr, fb_data, fb_we       registered framebuffer write (valid)
//   fb_ready                      framebuffer accept (ready)
//   busy                          FIFO non-empty, write pending or clearing
//   overflow                      sticky: in-range plot lost on full FIFO
//   drop_count                    saturating count of out-of-range plots
module plot_writer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int AW       = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8:0]    vga_x,
    input  logic [7:0]    vga_y,
    input  logic [2:0]    vga_colour,
    input  logic          vga_plot,
    input  logic          clear_start,
    input  logic [2:0]    clear_colour,
    output logic [AW-1:0] fb_addr,
    output logic [2:0]    fb_data,
    output logic          fb_we,
    input  logic          fb_ready,
    output logic          busy,
    output logic          overflow,
    output logic [15:0]   drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 3;
    localparam logic [AW-1:0] LAST_ADDR = AW'(SCREEN_W * SCREEN_H - 1);

    // Range check and linear address, computed before the FIFO
    logic          in_range;
    logic          plot_ok;
    logic          plot_bad;
    logic [AW-1:0] plot_addr;

    assign in_range  = (32'(vga_x) < SCREEN_W) && (32'(vga_y) < SCREEN_H);
    assign plot_ok   = vga_plot && in_range;
    assign plot_bad  = vga_plot && !in_range;
    assign plot_addr = AW'(vga_y) * AW'(SCREEN_W) + AW'(vga_x);

    // Plot FIFO; pointers carry an extra wrap bit to tell full from empty
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW:0]   wr_ptr_q;
    logic [PW:0]   rd_ptr_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = mem_q[rd_ptr_q[PW-1:0]];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    assign push       = plot_ok && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= {plot_addr, vga_colour};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
        end
    end

    // Status flags
    logic        overflow_q;
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (plot_ok && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (plot_bad && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Output register and control
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    data_q, data_d;
    logic          can_load;
    logic          drain;
    logic          clearing;

    // The output register may take new contents when empty or transferring
    assign can_load = !we_q || fb_ready;

`ifdef FB_CLEAR_EN
    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    state_t     state_q, state_d;
    logic       pend_q, pend_d;
    logic [2:0] ccol_q, ccol_d;

    assign clearing = (state_q == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            ccol_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ccol_q  <= ccol_d;
        end
    end
`else
    logic unused_clear;

    assign unused_clear = ^{clear_start, clear_colour};
    assign clearing     = 1'b0;
`endif

    always_comb begin
        we_d   = we_q;
        addr_d = addr_q;
        data_d = data_q;
        pop    = 1'b0;
        drain  = 1'b0;
`ifdef FB_CLEAR_EN
        state_d = state_q;
        pend_d  = pend_q;
        ccol_d  = ccol_q;
        unique case (state_q)
            RUN: begin
                if (clear_start && !pend_q) begin
                    ccol_d = clear_colour;
                end
                // A clear waits for any in-flight write to complete
                if (clear_start || pend_q) begin
                    if (can_load) begin
                        state_d = CLEAR;
                        pend_d  = 1'b0;
                        we_d    = 1'b1;
                        addr_d  = '0;
                        data_d  = ccol_d;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else begin
                    drain = 1'b1;
                end
            end
            CLEAR: begin
                // fb_we stays high for the whole sweep
                if (fb_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        we_d    = 1'b0;
                        state_d = RUN;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
`else
        drain = 1'b1;
`endif
        if (drain && can_load) begin
            if (!fifo_empty) begin
                pop    = 1'b1;
                we_d   = 1'b1;
                addr_d = head[EW-1:3];
                data_d = head[2:0];
            end else begin
                we_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_data    = data_q;
    assign busy       = !fifo_empty || we_q || clearing;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_plot_writer.sv
// tb_plot_writer: self-checking bench for plot_writer using a table of plots
// and a write scoreboard; clear tests depend on FB_CLEAR_EN.
module tb_plot_writer;

    logic        clk;
    logic        rst;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_count;

    plot_writer dut (
        .clk          (clk),
        .rst          (rst),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .fb_ready     (fb_ready),
        .busy         (busy),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
        logic        ok;
        logic [16:0] addr;
    } vec_t;

    typedef struct {
        logic [16:0] addr;
        logic [2:0]  data;
    } wr_t;

    vec_t tbl [9];
    wr_t  exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_cnt   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_plot(input int x, input int y, input int c);
        vga_x      = 9'(x);
        vga_y      = 8'(y);
        vga_colour = 3'(c);
        vga_plot   = 1'b1;
    endtask

    task automatic expw(input int a, input int d);
        wr_t e;
        e.addr = 17'(a);
        e.data = 3'(d);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(nm, busy, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        vga_plot = 1'b0;
        clear_start = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Write monitor: scoreboard compare plus hold-stable check while stalled
    logic        hold_v = 1'b0;
    logic [16:0] hold_a;
    logic [2:0]  hold_d;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_we", fb_we, 1);
                chk("hold_addr", fb_addr, hold_a);
                chk("hold_data", fb_data, hold_d);
            end
            if (fb_we && fb_ready) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0d, none expected",
                             fb_addr, fb_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", fb_addr, e.addr);
                    chk("wr_data", fb_data, e.data);
                end
            end
            hold_v = fb_we && !fb_ready;
            hold_a = fb_addr;
            hold_d = fb_data;
        end
    end

    initial begin
        int exp_drop;
        int wc;
        int n;
        tbl[0] = '{9'd100, 8'd50,  3'd4, 1'b1, 17'd16100};
        tbl[1] = '{9'd320, 8'd0,   3'd1, 1'b0, 17'd0};
        tbl[2] = '{9'd319, 8'd0,   3'd1, 1'b1, 17'd319};
        tbl[3] = '{9'd0,   8'd240, 3'd2, 1'b0, 17'd0};
        tbl[4] = '{9'd0,   8'd239, 3'd6, 1'b1, 17'd76480};
        tbl[5] = '{9'd511, 8'd255, 3'd7, 1'b0, 17'd0};
        tbl[6] = '{9'd5,   8'd2,   3'd3, 1'b1, 17'd645};
        tbl[7] = '{9'd160, 8'd120, 3'd5, 1'b1, 17'd38560};
        tbl[8] = '{9'd318, 8'd238, 3'd0, 1'b1, 17'd76478};

        vga_x = '0;
        vga_y = '0;
        vga_colour = '0;
        vga_plot = 1'b0;
        clear_start = 1'b0;
        clear_colour = '0;
        fb_ready = 1'b1;
        reset_dut();
        exp_drop = 0;

        @(negedge clk);
        chk("rst_we", fb_we, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_count, 0);

        // Single plot latency
        tick();
        set_plot(0, 0, 5);
        expw(0, 5);
        tick();
        vga_plot = 1'b0;
        @(negedge clk);
        chk("lat_we0", fb_we, 0);
        chk("lat_busy", busy, 1);
        @(negedge clk);
        chk("lat_we1", fb_we, 1);
        chk("lat_addr", fb_addr, 0);
        chk("lat_data", fb_data, 5);
        @(negedge clk);
        chk("lat_we2", fb_we, 0);
        chk("lat_idle", busy, 0);

        // Back-to-back corners
        tick();
        set_plot(319, 239, 2);
        expw(76799, 2);
        tick();
        set_plot(1, 1, 7);
        expw(321, 7);
        tick();
        vga_plot = 1'b0;
        @(negedge clk);
        chk("b2b_we0", fb_we, 1);
        chk("b2b_addr0", fb_addr, 76799);
        @(negedge clk);
        chk("b2b_we1", fb_we, 1);
        chk("b2b_addr1", fb_addr, 321);
        wait_idle("b2b_idle", 20);

        // Table of mixed in-range and out-of-range plots, back-to-back
        foreach (tbl[i]) begin
            tick();
            set_plot(tbl[i].x, tbl[i].y, tbl[i].c);
            if (tbl[i].ok) expw(tbl[i].addr, tbl[i].c);
            else exp_drop++;
        end
        tick();
        vga_plot = 1'b0;
        wait_idle("tbl_idle", 50);
        chk("tbl_drop", drop_count, exp_drop);
        chk("tbl_overflow", overflow, 0);
        chk("tbl_sb_empty", exp_q.size(), 0);

        // Fill to full with stall, then pop and push in the same cycle
        wc = wr_cnt;
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            set_plot(i, 0, i);
            expw(i, i % 8);
        end
        tick();
        set_plot(9, 0, 1);
        expw(9, 1);
        fb_ready = 1'b1;
        tick();
        vga_plot = 1'b0;
        @(negedge clk);
        chk("full_pp_overflow", overflow, 0);
        wait_idle("full_pp_idle", 50);
        chk("full_pp_writes", wr_cnt - wc, 10);
        chk("full_pp_sb_empty", exp_q.size(), 0);

        // Overflow: tenth plot into a full FIFO is lost
        wc = wr_cnt;
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            set_plot(i, 1, 7 - i);
            expw(320 + i, (7 - i) & 7);
        end
        tick();
        set_plot(9, 1, 4);
        @(negedge clk);
        chk("ovf_before", overflow, 0);
        tick();
        vga_plot = 1'b0;
        @(negedge clk);
        chk("ovf_after", overflow, 1);
        tick();
        fb_ready = 1'b1;
        wait_idle("ovf_idle", 50);
        chk("ovf_writes", wr_cnt - wc, 9);
        chk("ovf_sb_empty", exp_q.size(), 0);
        chk("ovf_sticky", overflow, 1);

`ifdef FB_CLEAR_EN
        // Full clear with a plot and a second clear_start injected mid-sweep
        reset_dut();
        wc = wr_cnt;
        tick();
        clear_start = 1'b1;
        clear_colour = 3'd3;
        for (int a = 0; a < 76800; a++) expw(a, 3);
        tick();
        clear_start = 1'b0;
        repeat (100) @(negedge clk);
        tick();
        set_plot(10, 0, 6);
        expw(10, 6);
        clear_start = 1'b1;
        clear_colour = 3'd1;
        tick();
        vga_plot = 1'b0;
        clear_start = 1'b0;
        n = 0;
        begin
            int low;
            low = 0;
            @(negedge clk);
            while (busy && n < 80000) begin
                @(negedge clk);
                n++;
            end
            chk("clr_idle", busy, 0);
            chk("clr_writes", wr_cnt - wc, 76801);
            chk("clr_sb_empty", exp_q.size(), 0);
            chk("clr_busy_low_early", low, 0);
        end

        // Reset during a clear abandons the sweep
        tick();
        clear_start = 1'b1;
        clear_colour = 3'd5;
        for (int a = 0; a <= 1000; a++) expw(a, 5);
        tick();
        clear_start = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(fb_we && fb_addr == 17'd1000) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rstclr_reached", fb_addr, 1000);
        #2;
        rst = 1'b1;
        #1;
        chk("rstclr_we", fb_we, 0);
        chk("rstclr_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        wc = wr_cnt;
        repeat (20) @(negedge clk);
        chk("rstclr_no_writes", wr_cnt - wc, 0);
        chk("rstclr_idle", busy, 0);
        chk("rstclr_sb_empty", exp_q.size(), 0);
`else
        // Without the clear feature, clear_start is ignored
        wc = wr_cnt;
        tick();
        clear_start = 1'b1;
        clear_colour = 3'd3;
        tick();
        clear_start = 1'b0;
        @(negedge clk);
        chk("noclr_busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("noclr_writes", wr_cnt - wc, 0);
        chk("noclr_idle", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_writer.md
Name: plot_writer

Overview:
- Downstream of the Mandelbrot pixel generator: consumes its vga_x/vga_y/vga_colour/vga_plot strobes and turns them into linear framebuffer writes for a 320x240, 3-bit-colour screen.
- Decouples the generator, which has no backpressure, from a framebuffer port that may stall, using a small FIFO.
- Provides a clear-screen sweep, rejects out-of-range coordinates and keeps error counters.

Parameters:
- DEPTH, 8, plot FIFO entries; must be a power of 2, at least 2.
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- AW, 17, framebuffer address width; SCREEN_W*SCREEN_H must be at most 2^AW.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- vga_x  in  9  plot column.
- vga_y  in  8  plot row.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  plot strobe; one pixel per cycle when high.
- clear_start  in  1  single-cycle pulse requesting a full-screen clear.
- clear_colour  in  3  fill colour, sampled on clear_start.
- fb_addr  out  AW  framebuffer word address.
- fb_data  out  3  framebuffer write colour.
- fb_we  out  1  write valid.
- fb_ready  in  1  framebuffer accepts; a transfer happens on an edge where fb_we && fb_ready.
- busy  out  1  high while the FIFO is non-empty, a write is pending, or a clear is running.
- overflow  out  1  sticky flag: a valid plot was lost because the FIFO was full.
- drop_count  out  16  count of out-of-range plots; saturates at 16'hFFFF.

Behaviour:
- Reset, asynchronous: fb_addr=0, fb_data=0, fb_we=0, busy=0, overflow=0, drop_count=0; FIFO emptied; state=RUN. Reset mid-clear abandons the sweep immediately; no further writes occur.
- Range check on vga_plot:
  - x<SCREEN_W and y<SCREEN_H: enqueue {addr = y*SCREEN_W + x, colour}. Compute the address before the FIFO, e.g. (y<<8)+(y<<6)+x for the default width.
  - Otherwise: discard and increment drop_count (saturating). Never enqueued.
- FIFO full while an in-range plot arrives: plot discarded, overflow set to 1. overflow is cleared only by rst. A pop and a push in the same cycle while full succeed; the entry is not lost.
- Output register, valid/ready:
  - fb_we, fb_addr and fb_data are registered.
  - Once fb_we=1, fb_addr and fb_data hold stable until the transfer edge.
  - After a transfer, the next FIFO head is loaded the same edge if available; otherwise fb_we drops.
  - Latency: plot strobe at edge N with FIFO empty and fb_we=0 gives fb_we=1 after edge N+1. Back-to-back writes sustain 1 per cycle when fb_ready=1.
- Write order is plot-arrival order.
- FSM states:
  - RUN: drain the FIFO to the framebuffer.
  - CLEAR: sweep fb_addr from 0 to SCREEN_W*SCREEN_H-1 with data=clear_colour latched at start. The counter advances only on transfer edges. After the transfer of the last address, go to RUN.
- RUN to CLEAR on clear_start, once any in-flight fb_we transfer completes. The clear waits for that write; it never overwrites fb_addr/fb_data mid-handshake.
- During CLEAR, plots are still range-checked and enqueued (or dropped). They are drained only after the clear, so they are never erased.
- clear_start during CLEAR is ignored; the sweep is not restarted.
- busy is combinational OR of: FIFO non-empty, fb_we, state==CLEAR.

Optional Feature:
- FB_CLEAR_EN.
  - Defined: the CLEAR state and sweep counter exist as described.
  - Undefined: no CLEAR state or counter is synthesized; clear_start and clear_colour are ignored; the block only ever drains plots.
- Port list is identical in both builds.

Test Plan:
- After reset, plot (x=0,y=0,c=5) with fb_ready=1 -> next cycle fb_we=1, fb_addr=0, fb_data=5; fb_we=0 the cycle after; busy then 0.
- Plot (319,239,c=2), then (1,1,c=7) back-to-back, fb_ready=1 -> writes addr 76799 data 2, then addr 321 data 7, consecutive cycles.
- Plots (320,0), (0,240) and (511,255) -> no fb_we, drop_count=3, overflow=0.
- fb_ready=0; 9 in-range plots in consecutive cycles with x=0..8, y=0 -> first held in the output register, next 8 fill the FIFO, none lost, overflow=0. A 10th plot sets overflow=1. Raising fb_ready yields 9 writes at addr 0..8 in order.
- With FB_CLEAR_EN: clear_start with clear_colour=3, fb_ready=1 -> 76800 writes at addr 0..76799, data 3, busy high throughout. A plot (10,0,c=6) injected mid-clear is written as addr 10 data 6 after addr 76799.
- Assert rst at clear address 1000 -> fb_we=0 immediately; after release busy=0 and no further writes. Without FB_CLEAR_EN, clear_start produces no writes.
